// File: rtl/lf_meas_ctrl_pkg.sv
// Shared types and constants for the low-frequency counter display path
// (counter, measurement sequencer, hold register and seg7 multiplexer).
package lf_pkg;

    localparam int DIG_W = 5;
    localparam logic [DIG_W-1:0] DASH_CODE = 5'h10;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        WAIT  = 3'd2,
        LOAD  = 3'd3,
        TOUT  = 3'd4,
        HOLD  = 3'd5
    } lf_state_t;

    // Index 3 is the most significant displayed digit.
    typedef logic [3:0][DIG_W-1:0] lf_digits_t;

    function automatic lf_digits_t lf_fill_digits(input logic [DIG_W-1:0] code);
        lf_digits_t digits;
        for (int i = 0; i < 4; i++) begin
            digits[i] = code;
        end
        return digits;
    endfunction

    function automatic int lf_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/lf_meas_ctrl_if.sv
// Bundle of the sequencer's handshake and digit signals: the counter side,
// the user trigger inputs and the held digits going to the display.
interface lf_meas_ctrl_if;
    import lf_pkg::*;

    logic             run;
    logic             single;
    logic             cnt_done;
    logic [DIG_W-1:0] dig3_in;
    logic [DIG_W-1:0] dig2_in;
    logic [DIG_W-1:0] dig1_in;
    logic [DIG_W-1:0] dig0_in;
    logic             cnt_start;
    logic [DIG_W-1:0] dig3_out;
    logic [DIG_W-1:0] dig2_out;
    logic [DIG_W-1:0] dig1_out;
    logic [DIG_W-1:0] dig0_out;
    logic             load;
    logic             timeout;
    logic             busy;

    modport master (
        output run, single, cnt_done, dig3_in, dig2_in, dig1_in, dig0_in,
        input  cnt_start, dig3_out, dig2_out, dig1_out, dig0_out, load, timeout, busy
    );

    modport slave (
        input  run, single, cnt_done, dig3_in, dig2_in, dig1_in, dig0_in,
        output cnt_start, dig3_out, dig2_out, dig1_out, dig0_out, load, timeout, busy
    );

endinterface

// File: rtl/lf_meas_ctrl_timer.sv
// Shared up-counter with terminal-count compare; it saturates at the terminal
// value so it never wraps, and is cleared by the sequencer on state entry.
module lf_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_clear,
    input  logic         i_inc,
    input  logic [W-1:0] i_terminal,
    output logic         o_tc
);

    logic [W-1:0] r_count;

    assign o_tc = (r_count == i_terminal);

    always_ff @(posedge clk) begin
        if (reset || i_clear) begin
            r_count <= '0;
        end else if (i_inc && !o_tc) begin
            r_count <= r_count + W'(1);
        end
    end

endmodule

// File: rtl/lf_meas_ctrl.sv
// Measurement sequencer: trigger counter, wait for done or timeout, latch digits, hold.
// Optional macro LF_CTRL_CHANGE_ONLY_EN: only pulse load when the displayed value changes.
module lf_meas_ctrl
    import lf_pkg::*;
#(
    parameter int HOLD_CYCLES    = 50000000,
    parameter int TIMEOUT_CYCLES = 200000000
) (
    input  logic          clk,
    input  logic          reset,
    lf_meas_ctrl_if.slave bus
);

    localparam int TIMER_W = $clog2(lf_max(HOLD_CYCLES, TIMEOUT_CYCLES));
    localparam logic [TIMER_W-1:0] HOLD_TC = TIMER_W'(HOLD_CYCLES - 1);
    localparam logic [TIMER_W-1:0] TOUT_TC = TIMER_W'(TIMEOUT_CYCLES - 1);

    lf_state_t          r_state;
    lf_state_t          w_nextState;
    logic               w_timerClear;
    logic               w_timerInc;
    logic [TIMER_W-1:0] w_terminal;
    logic               w_timerTc;

    lf_digits_t         w_digIn;
    lf_digits_t         r_digits;
    lf_digits_t         w_nextDigits;
    logic               w_loadEnable;
    logic               w_nextLoad;
    logic               w_nextTimeout;
    logic               r_load;
    logic               r_timeout;
    logic               r_cntStart;
    logic               r_busy;

    assign w_digIn = {bus.dig3_in, bus.dig2_in, bus.dig1_in, bus.dig0_in};

    assign bus.cnt_start = r_cntStart;
    assign bus.load      = r_load;
    assign bus.timeout   = r_timeout;
    assign bus.busy      = r_busy;
    assign bus.dig3_out  = r_digits[3];
    assign bus.dig2_out  = r_digits[2];
    assign bus.dig1_out  = r_digits[1];
    assign bus.dig0_out  = r_digits[0];

    lf_timer #(
        .W (TIMER_W)
    ) u_timer (
        .clk        (clk),
        .reset      (reset),
        .i_clear    (w_timerClear),
        .i_inc      (w_timerInc),
        .i_terminal (w_terminal),
        .o_tc       (w_timerTc)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // One timer serves both WAIT (timeout) and HOLD; it is zeroed in every other state.
    always_comb begin
        w_nextState  = r_state;
        w_timerClear = 1'b0;
        w_timerInc   = 1'b0;
        w_terminal   = TOUT_TC;
        case (r_state)
            IDLE: begin
                w_timerClear = 1'b1;
                if (bus.run || bus.single) begin
                    w_nextState = START;
                end
            end
            START: begin
                w_timerClear = 1'b1;
                w_nextState  = WAIT;
            end
            WAIT: begin
                w_timerInc = 1'b1;
                if (bus.cnt_done) begin
                    w_nextState = LOAD;
                end else if (w_timerTc) begin
                    w_nextState = TOUT;
                end
            end
            LOAD, TOUT: begin
                w_timerClear = 1'b1;
                w_nextState  = HOLD;
            end
            HOLD: begin
                w_timerInc = 1'b1;
                w_terminal = HOLD_TC;
                if (w_timerTc) begin
                    w_nextState = bus.run ? START : IDLE;
                end
            end
            default: begin
                w_timerClear = 1'b1;
                w_nextState  = IDLE;
            end
        endcase
    end

`ifdef LF_CTRL_CHANGE_ONLY_EN
    assign w_loadEnable = (w_digIn != r_digits) || r_timeout;
`else
    assign w_loadEnable = 1'b1;
`endif

    // Digits are captured straight into the hold register on the WAIT exit edge,
    // so load and the new digits appear together one cycle after cnt_done.
    always_comb begin
        w_nextDigits  = r_digits;
        w_nextLoad    = 1'b0;
        w_nextTimeout = r_timeout;
        if (r_state == WAIT && w_nextState == LOAD) begin
            if (w_loadEnable) begin
                w_nextDigits  = w_digIn;
                w_nextLoad    = 1'b1;
                w_nextTimeout = 1'b0;
            end
        end else if (r_state == WAIT && w_nextState == TOUT) begin
            w_nextDigits  = lf_fill_digits(DASH_CODE);
            w_nextLoad    = 1'b1;
            w_nextTimeout = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cntStart <= 1'b0;
            r_busy     <= 1'b0;
            r_load     <= 1'b0;
            r_timeout  <= 1'b0;
            r_digits   <= '0;
        end else begin
            r_cntStart <= (w_nextState == START);
            r_busy     <= (w_nextState != IDLE);
            r_load     <= w_nextLoad;
            r_timeout  <= w_nextTimeout;
            r_digits   <= w_nextDigits;
        end
    end

endmodule

// File: tb/tb_lf_meas_ctrl.sv
// Directed bench for lf_meas_ctrl with HOLD_CYCLES=4, TIMEOUT_CYCLES=10.
// Honours LF_CTRL_CHANGE_ONLY_EN for the repeated-result load expectation.
module tb_lf_meas_ctrl;
    import lf_pkg::*;

    localparam int HOLD = 4;
    localparam int TMO  = 10;

    localparam logic [19:0] D0000 = 20'h0;
    localparam logic [19:0] D1234 = {5'd1, 5'd2, 5'd3, 5'd4};
    localparam logic [19:0] D5678 = {5'd5, 5'd6, 5'd7, 5'd8};
    localparam logic [19:0] D2468 = {5'd2, 5'd4, 5'd6, 5'd8};
    localparam logic [19:0] D1357 = {5'd1, 5'd3, 5'd5, 5'd7};
    localparam logic [19:0] D3141 = {5'd3, 5'd1, 5'd4, 5'd1};
    localparam logic [19:0] D7777 = {5'd7, 5'd7, 5'd7, 5'd7};
    localparam logic [19:0] D9876 = {5'd9, 5'd8, 5'd7, 5'd6};
    localparam logic [19:0] DDASH = {5'h10, 5'h10, 5'h10, 5'h10};

`ifdef LF_CTRL_CHANGE_ONLY_EN
    localparam logic REPEAT_LOAD = 1'b0;
`else
    localparam logic REPEAT_LOAD = 1'b1;
`endif

    logic clk = 1'b0;
    logic reset;
    int   vectors = 0;
    int   miscompares = 0;

    lf_meas_ctrl_if bus ();

    lf_meas_ctrl #(
        .HOLD_CYCLES    (HOLD),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Control view is {cnt_start, load, timeout, busy}.
    logic [3:0]  obsCtl;
    logic [19:0] obsDig;
    assign obsCtl = {bus.cnt_start, bus.load, bus.timeout, bus.busy};
    assign obsDig = {bus.dig3_out, bus.dig2_out, bus.dig1_out, bus.dig0_out};

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic applyStimulus(input logic run, input logic single, input logic done,
                                 input logic [19:0] dig);
        bus.run      = run;
        bus.single   = single;
        bus.cnt_done = done;
        {bus.dig3_in, bus.dig2_in, bus.dig1_in, bus.dig0_in} = dig;
    endtask

    task automatic checkOutput(input string tag, input logic [23:0] observed,
                               input logic [23:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, D0000);
        step(2);
        checkOutput("reset_ctl", obsCtl, 4'b0000);
        checkOutput("reset_dig", obsDig, D0000);
        reset = 1'b0;
        step(1);
        checkOutput("idle_ctl", obsCtl, 4'b0000);

        // Single shot with a normal answer
        applyStimulus(1'b0, 1'b1, 1'b0, D0000); step(1);
        checkOutput("t1_start", obsCtl, 4'b1001);
        applyStimulus(1'b0, 1'b0, 1'b0, D0000); step(1);
        checkOutput("t1_start_width", obsCtl, 4'b0001);
        step(3);
        checkOutput("t1_wait_noload", obsCtl, 4'b0001);
        applyStimulus(1'b0, 1'b0, 1'b1, D1234); step(1);
        checkOutput("t1_load_ctl", obsCtl, 4'b0101);
        checkOutput("t1_load_dig", obsDig, D1234);
        applyStimulus(1'b0, 1'b0, 1'b0, D0000); step(1);
        checkOutput("t1_hold0", obsCtl, 4'b0001);
        step(3);
        checkOutput("t1_hold3", obsCtl, 4'b0001);
        step(1);
        checkOutput("t1_idle_ctl", obsCtl, 4'b0000);
        checkOutput("t1_idle_dig", obsDig, D1234);

        // Timeout, then a good measurement clears the flag
        applyStimulus(1'b0, 1'b1, 1'b0, D0000); step(1);
        checkOutput("t2_start", obsCtl, 4'b1001);
        applyStimulus(1'b0, 1'b0, 1'b0, D0000); step(1);
        step(9);
        checkOutput("t2_wait9", obsCtl, 4'b0001);
        step(1);
        checkOutput("t2_tout_ctl", obsCtl, 4'b0111);
        checkOutput("t2_tout_dig", obsDig, DDASH);
        step(1);
        checkOutput("t2_hold0", obsCtl, 4'b0011);
        step(4);
        checkOutput("t2_idle_ctl", obsCtl, 4'b0010);
        step(3);
        checkOutput("t2_idle_keep", obsCtl, 4'b0010);
        checkOutput("t2_idle_dig", obsDig, DDASH);
        applyStimulus(1'b0, 1'b1, 1'b0, D0000); step(1);
        checkOutput("t2_restart", obsCtl, 4'b1011);
        applyStimulus(1'b0, 1'b0, 1'b0, D0000); step(1);
        applyStimulus(1'b0, 1'b0, 1'b1, D5678); step(1);
        checkOutput("t2_clear_ctl", obsCtl, 4'b0101);
        checkOutput("t2_clear_dig", obsDig, D5678);
        applyStimulus(1'b0, 1'b0, 1'b0, D0000); step(5);
        checkOutput("t2_end_idle", obsCtl, 4'b0000);

        // Continuous mode: nine-cycle period, then run dropped mid-WAIT
        applyStimulus(1'b1, 1'b0, 1'b0, D0000); step(1);
        checkOutput("t3_start1", obsCtl, 4'b1001);
        step(3);
        applyStimulus(1'b1, 1'b0, 1'b1, D2468); step(1);
        checkOutput("t3_load1_ctl", obsCtl, 4'b0101);
        checkOutput("t3_load1_dig", obsDig, D2468);
        applyStimulus(1'b1, 1'b0, 1'b0, D0000); step(4);
        checkOutput("t3_hold3", obsCtl, 4'b0001);
        step(1);
        checkOutput("t3_start2", obsCtl, 4'b1001);
        step(2);
        applyStimulus(1'b0, 1'b0, 1'b0, D0000); step(1);
        applyStimulus(1'b0, 1'b0, 1'b1, D1357); step(1);
        checkOutput("t3_load2_ctl", obsCtl, 4'b0101);
        checkOutput("t3_load2_dig", obsDig, D1357);
        applyStimulus(1'b0, 1'b0, 1'b0, D0000); step(4);
        checkOutput("t3_hold3b", obsCtl, 4'b0001);
        for (int i = 0; i < 5; i++) begin
            step(1);
            checkOutput("t3_no_restart", obsCtl, 4'b0000);
        end

        // Done coincident with terminal count, ignored single/done in HOLD
        applyStimulus(1'b0, 1'b1, 1'b0, D0000); step(1);
        checkOutput("t4_start", obsCtl, 4'b1001);
        applyStimulus(1'b0, 1'b0, 1'b0, D0000); step(1);
        step(9);
        applyStimulus(1'b0, 1'b0, 1'b1, D3141); step(1);
        checkOutput("t4_done_wins_ctl", obsCtl, 4'b0101);
        checkOutput("t4_done_wins_dig", obsDig, D3141);
        applyStimulus(1'b0, 1'b0, 1'b0, D0000); step(1);
        applyStimulus(1'b0, 1'b1, 1'b0, D0000); step(1);
        checkOutput("t4_hold1", obsCtl, 4'b0001);
        applyStimulus(1'b0, 1'b0, 1'b1, D7777); step(1);
        checkOutput("t4_stray_ctl", obsCtl, 4'b0001);
        checkOutput("t4_stray_dig", obsDig, D3141);
        applyStimulus(1'b0, 1'b0, 1'b0, D0000); step(2);
        checkOutput("t4_idle_ctl", obsCtl, 4'b0000);
        checkOutput("t4_idle_dig", obsDig, D3141);
        step(1);
        checkOutput("t4_single_ignored", obsCtl, 4'b0000);

        // Reset in WAIT, then a late answer
        applyStimulus(1'b0, 1'b1, 1'b0, D0000); step(1);
        applyStimulus(1'b0, 1'b0, 1'b0, D0000); step(2);
        checkOutput("t5_wait", obsCtl, 4'b0001);
        reset = 1'b1; step(1);
        checkOutput("t5_reset_ctl", obsCtl, 4'b0000);
        checkOutput("t5_reset_dig", obsDig, D0000);
        reset = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b1, D9876); step(1);
        checkOutput("t5_late_ctl", obsCtl, 4'b0000);
        checkOutput("t5_late_dig", obsDig, D0000);
        applyStimulus(1'b0, 1'b0, 1'b0, D0000); step(1);
        checkOutput("t5_no_start", obsCtl, 4'b0000);

        // Same result twice
        applyStimulus(1'b0, 1'b1, 1'b0, D0000); step(1);
        applyStimulus(1'b0, 1'b0, 1'b0, D0000); step(1);
        applyStimulus(1'b0, 1'b0, 1'b1, D7777); step(1);
        checkOutput("t6_first_ctl", obsCtl, 4'b0101);
        checkOutput("t6_first_dig", obsDig, D7777);
        applyStimulus(1'b0, 1'b0, 1'b0, D0000); step(5);
        applyStimulus(1'b0, 1'b1, 1'b0, D0000); step(1);
        checkOutput("t6_start2", obsCtl, 4'b1001);
        applyStimulus(1'b0, 1'b0, 1'b0, D0000); step(1);
        applyStimulus(1'b0, 1'b0, 1'b1, D7777); step(1);
        checkOutput("t6_second_ctl", obsCtl, {1'b0, REPEAT_LOAD, 1'b0, 1'b1});
        checkOutput("t6_second_dig", obsDig, D7777);
        applyStimulus(1'b0, 1'b0, 1'b0, D0000); step(5);
        checkOutput("t6_idle", obsCtl, 4'b0000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
